// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter, MSB first, with a per-bit sample strobe.
// Words can be streamed gaplessly by handing off on the last bit's strobe.
module shift_serializer #(
   parameter int WIDTH = 16,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             serial_o,
   output logic             shift_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_MAX  = BW'(WIDTH - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]    bit_cnt, bit_n;
   logic [TW-1:0]    tick_cnt, tick_n;
   logic             last_tick, xfer;

   assign last_tick = (tick_cnt == TICK_MAX);
   assign busy_o    = (state == SHIFT);
   assign serial_o  = busy_o & shreg[WIDTH-1];
   assign shift_o   = busy_o & last_tick;
   assign done_o    = shift_o & (bit_cnt == BIT_MAX);
   // Ready never looks at valid_i, so the handshake has no comb loop.
   assign ready_o   = (state == IDLE) | done_o;
   assign xfer      = valid_i & ready_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         tick_cnt <= '0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_n;
         tick_cnt <= tick_n;
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      bit_n   = bit_cnt;
      tick_n  = tick_cnt;
      if (xfer) begin
         state_n = SHIFT;
         shreg_n = data_i;
         bit_n   = '0;
         tick_n  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               shreg_n = '0;
            end
            SHIFT: begin
               if (!last_tick) begin
                  tick_n = tick_cnt + 1'b1;
               end else if (bit_cnt == BIT_MAX) begin
                  state_n = IDLE;
                  shreg_n = '0;
                  bit_n   = '0;
                  tick_n  = '0;
               end else begin
                  shreg_n = {shreg[WIDTH-2:0], 1'b0};
                  bit_n   = bit_cnt + 1'b1;
                  tick_n  = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: DIV=1 and DIV=3 instances, each feeding a
// model receiver shift register; expected bits come from word/cycle arithmetic.
module tb_shift_serializer;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [15:0] data [2];
   logic [1:0]  valid, ready, ser, shf, busy, done;
   logic [15:0] rx [2];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_serializer #(.WIDTH(16), .DIV(1)) dut1 (
      .clk(clk), .reset(rst[0]), .data_i(data[0]), .valid_i(valid[0]),
      .ready_o(ready[0]), .serial_o(ser[0]), .shift_o(shf[0]),
      .busy_o(busy[0]), .done_o(done[0]));

   shift_serializer #(.WIDTH(16), .DIV(3)) dut3 (
      .clk(clk), .reset(rst[1]), .data_i(data[1]), .valid_i(valid[1]),
      .ready_o(ready[1]), .serial_o(ser[1]), .shift_o(shf[1]),
      .busy_o(busy[1]), .done_o(done[1]));

   initial begin
      rx[0] = '0;
      rx[1] = '0;
   end

   always @(posedge clk) begin
      if (shf[0]) rx[0] <= {rx[0][14:0], ser[0]};
      if (shf[1]) rx[1] <= {rx[1][14:0], ser[1]};
   end

   function automatic int divk(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input int k, input logic [15:0] w);
      data[k]  = w;
      valid[k] = 1'b1;
   endtask

   // Word w is accepted on the next edge. At cycle rej (0 = never) the next
   // word nw is presented and held until accepted on the done cycle.
   task automatic run_word(input int k, input logic [15:0] w, input int rej,
                           input logic [15:0] nw, input bit chkp,
                           input logic [15:0] pw);
      int d, n, idx;
      d = divk(k);
      n = 16 * d;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            valid[k] = 1'b0;
            if (chkp) check("rx_prev", rx[k], pw);
         end
         if (rej != 0 && c == rej) start(k, nw);
         idx = (c - 1) / d;
         check("serial", ser[k], w[15 - idx]);
         check("shift", shf[k], (c % d) == 0);
         check("done", done[k], c == n);
         check("ready", ready[k], c == n);
         check("busy", busy[k], 1'b1);
      end
   endtask

   task automatic idle_chk(input int k, input logic [15:0] w);
      @(posedge clk);
      #1;
      check("idle_busy", busy[k], 1'b0);
      check("idle_ready", ready[k], 1'b1);
      check("idle_serial", ser[k], 1'b0);
      check("idle_shift", shf[k], 1'b0);
      check("rx_word", rx[k], w);
   endtask

   initial begin
      logic [15:0] w, nw;
      int rej, d;
      rst      = 2'b11;
      valid    = '0;
      data[0]  = '0;
      data[1]  = '0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_ready", ready[k], 1'b1);
         check("rst_busy", busy[k], 1'b0);
         check("rst_serial", ser[k], 1'b0);
         check("rst_shift", shf[k], 1'b0);
         check("rst_done", done[k], 1'b0);
      end
      @(negedge clk);
      rst = 2'b00;

      // idle hold
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            check("hold_shift", shf[k], 1'b0);
            check("hold_done", done[k], 1'b0);
            check("hold_serial", ser[k], 1'b0);
            check("hold_ready", ready[k], 1'b1);
         end
      end

      // single word
      start(0, 16'hA5C3);
      run_word(0, 16'hA5C3, 0, 16'h0, 1'b0, 16'h0);
      idle_chk(0, 16'hA5C3);

      // back-to-back, valid held the whole time
      start(0, 16'hFFFF);
      run_word(0, 16'hFFFF, 1, 16'h0001, 1'b0, 16'h0);
      run_word(0, 16'h0001, 0, 16'h0, 1'b1, 16'hFFFF);
      idle_chk(0, 16'h0001);

      // busy rejection at bit 5
      start(0, 16'hC0DE);
      run_word(0, 16'hC0DE, 6, 16'h1234, 1'b0, 16'h0);
      run_word(0, 16'h1234, 0, 16'h0, 1'b1, 16'hC0DE);
      idle_chk(0, 16'h1234);

      // DIV=3
      start(1, 16'h8001);
      run_word(1, 16'h8001, 0, 16'h0, 1'b0, 16'h0);
      idle_chk(1, 16'h8001);

      // async reset during bit 7
      start(0, 16'hC3A5);
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) valid[0] = 1'b0;
      end
      check("pre_rst_busy", busy[0], 1'b1);
      #2;
      rst[0] = 1'b1;
      #1;
      check("arst_serial", ser[0], 1'b0);
      check("arst_shift", shf[0], 1'b0);
      check("arst_busy", busy[0], 1'b0);
      check("arst_ready", ready[0], 1'b1);
      @(negedge clk);
      rst[0] = 1'b0;
      @(posedge clk);
      #1;
      start(0, 16'h00FF);
      run_word(0, 16'h00FF, 0, 16'h0, 1'b0, 16'h0);
      idle_chk(0, 16'h00FF);

      // random streams, with random mid-word valid assertion
      for (int k = 0; k < 2; k++) begin
         d  = divk(k);
         nw = 16'($urandom);
         start(k, nw);
         w  = 16'h0;
         for (int i = 0; i < 6; i++) begin
            logic [15:0] cur;
            cur = nw;
            nw  = 16'($urandom);
            rej = (i == 5) ? 0 : int'($urandom_range(1, 16 * d));
            run_word(k, cur, rej, nw, i > 0, w);
            w = cur;
         end
         idle_chk(k, w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
